// File: rtl/branch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_sequencer_pkg
//  Description : Shared definitions for the branch sequencer. It holds the
//                BranchSelect condition codes, the controller state type,
//                the default parameter values and a helper that classifies
//                the selects which need a ULA compare.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_sequencer_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_ULA_LATENCY  = 1;
    localparam int DEF_FLUSH_CYCLES = 2;

    // BranchSelect condition codes. Encodings 101/110/111 all mean "never".
    localparam logic [2:0] BR_UNCOND = 3'b000;
    localparam logic [2:0] BR_EQ     = 3'b001;
    localparam logic [2:0] BR_NE     = 3'b010;
    localparam logic [2:0] BR_GT     = 3'b011;
    localparam logic [2:0] BR_LT     = 3'b100;
    localparam logic [2:0] BR_NONE   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMPARE  = 2'd1,
        ST_RESOLVE  = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    // Only the four true conditions need the operands compared.
    function automatic logic needs_compare(input logic [2:0] select);
        return (select == BR_EQ) || (select == BR_NE) ||
               (select == BR_GT) || (select == BR_LT);
    endfunction

endpackage : branch_sequencer_pkg
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cond_eval
//  Description : Combinational branch condition evaluator. It decides
//                whether a branch is taken from the condition code and the
//                two's-complement difference A-B returned by the ULA.
//  Ports       : select [2:0]           condition code (BR_*)
//                result [DATA_WIDTH-1:0] ULA difference A-B
//                taken                   1 when the branch must be taken
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_eval
    import branch_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [2:0]            select,
    input  logic [DATA_WIDTH-1:0] result,
    output logic                  taken
);

    logic w_zero;
    logic w_neg;

    assign w_zero = (result == '0);
    assign w_neg  = result[DATA_WIDTH-1];

    always_comb begin
        taken = 1'b0;
        case (select)
            BR_UNCOND: taken = 1'b1;
            BR_EQ:     taken = w_zero;
            BR_NE:     taken = !w_zero;
            BR_GT:     taken = !w_neg && !w_zero;   // signed result > 0
            BR_LT:     taken = w_neg;               // signed result < 0
            default:   taken = 1'b0;
        endcase
    end

endmodule : branch_cond_eval
`default_nettype wire

// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_sequencer
//  Description : Resolves one branch/jump at a time. A request is latched in
//                IDLE, conditional branches run a subtract compare on the
//                ULA, the condition is evaluated on the difference and a
//                taken branch strobes the PC load and holds Flush.
//  Ports       : clock, reset          clock / async active-high reset
//                BranchReq, BranchReady request handshake (ready in IDLE)
//                BranchSelect, RegA, RegB, BranchTarget  request payload
//                ULAopA, ULAopB, ULASub, ULAout          ULA interface
//                PCWrite, PCNext        one-cycle PC redirect
//                Flush, Stall           pipeline control
//                Resolved, Taken        decision pulse and outcome
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int ULA_LATENCY  = DEF_ULA_LATENCY,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  BranchReq,
    output logic                  BranchReady,
    input  logic [2:0]            BranchSelect,
    input  logic [DATA_WIDTH-1:0] RegA,
    input  logic [DATA_WIDTH-1:0] RegB,
    input  logic [ADDR_WIDTH-1:0] BranchTarget,
    output logic [DATA_WIDTH-1:0] ULAopA,
    output logic [DATA_WIDTH-1:0] ULAopB,
    output logic                  ULASub,
    input  logic [DATA_WIDTH-1:0] ULAout,
    output logic                  PCWrite,
    output logic [ADDR_WIDTH-1:0] PCNext,
    output logic                  Flush,
    output logic                  Stall,
    output logic                  Resolved,
    output logic                  Taken
);

    localparam int C_CMP_CNT_W = $clog2(ULA_LATENCY) + 1;
    localparam int C_FLS_CNT_W = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [C_CMP_CNT_W-1:0] C_CMP_LAST = C_CMP_CNT_W'(ULA_LATENCY - 1);
    localparam logic [C_FLS_CNT_W-1:0] C_FLS_LAST = C_FLS_CNT_W'(FLUSH_CYCLES - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [C_CMP_CNT_W-1:0]  r_cmp_cnt;
    logic [C_FLS_CNT_W-1:0]  r_flush_cnt;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [2:0]              r_sel;

    logic                    w_accept;
    logic                    w_cmp_done;
    logic                    w_flush_done;
    logic [2:0]              w_eval_sel;
    logic [DATA_WIDTH-1:0]   w_eval_result;
    logic                    w_eval_taken;
    logic                    w_ula_sub_next;
    logic                    w_resolved_next;
    logic                    w_taken_next;
    logic                    w_pc_write_next;
    logic                    w_flush_next;

    assign BranchReady  = (r_state == ST_IDLE);
    assign Stall        = (r_state != ST_IDLE);
    assign w_accept     = BranchReq && (r_state == ST_IDLE);
    assign w_cmp_done   = (r_state == ST_COMPARE) && (r_cmp_cnt == C_CMP_LAST);
    assign w_flush_done = (r_state == ST_REDIRECT) && (r_flush_cnt == C_FLS_LAST);

    // Taken is a registered output that must be valid in the RESOLVE cycle,
    // so the condition is evaluated one cycle early on the values that are
    // being latched at that edge: the live select when coming from IDLE,
    // the live ULA result when coming from COMPARE.
    assign w_eval_sel    = (r_state == ST_IDLE)    ? BranchSelect : r_sel;
    assign w_eval_result = (r_state == ST_COMPARE) ? ULAout       : r_result;

    branch_cond_eval #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cond_eval (
        .select (w_eval_sel),
        .result (w_eval_result),
        .taken  (w_eval_taken)
    );

    // State register and the per-state cycle counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cmp_cnt   <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cmp_cnt   <= ((r_state == ST_COMPARE) && !w_cmp_done)
                           ? r_cmp_cnt + 1'b1 : '0;
            r_flush_cnt <= ((r_state == ST_REDIRECT) && !w_flush_done)
                           ? r_flush_cnt + 1'b1 : '0;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = needs_compare(BranchSelect) ? ST_COMPARE : ST_RESOLVE;
                end
            end
            ST_COMPARE: begin
                if (w_cmp_done) begin
                    w_state_next = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                w_state_next = Taken ? ST_REDIRECT : ST_IDLE;
            end
            ST_REDIRECT: begin
                if (w_flush_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs.
    always_comb begin
        w_ula_sub_next  = (w_state_next == ST_COMPARE);
        w_resolved_next = (w_state_next == ST_RESOLVE);
        w_taken_next    = w_resolved_next && w_eval_taken;
        w_pc_write_next = (r_state == ST_RESOLVE) && (w_state_next == ST_REDIRECT);
        w_flush_next    = (w_state_next == ST_REDIRECT);
    end

    // Request latches, compare result latch and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ULAopA   <= '0;
            ULAopB   <= '0;
            PCNext   <= '0;
            r_sel    <= '0;
            r_result <= '0;
            ULASub   <= 1'b0;
            Resolved <= 1'b0;
            Taken    <= 1'b0;
            PCWrite  <= 1'b0;
            Flush    <= 1'b0;
        end else begin
            if (w_accept) begin
                ULAopA <= RegA;
                ULAopB <= RegB;
                PCNext <= BranchTarget;
                r_sel  <= BranchSelect;
            end
            if (w_cmp_done) begin
                r_result <= ULAout;
            end
            ULASub   <= w_ula_sub_next;
            Resolved <= w_resolved_next;
            Taken    <= w_taken_next;
            PCWrite  <= w_pc_write_next;
            Flush    <= w_flush_next;
        end
    end

endmodule : branch_sequencer
`default_nettype wire

// File: tb/tb_branch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_sequencer
//  Description : Self-checking bench for branch_sequencer. Two instances are
//                built, one with ULA_LATENCY=1 and one with ULA_LATENCY=3,
//                each with a small ULA model that only returns a valid
//                difference once ULASub has been high for the latency.
//                Expected traces come from a timeline model of a branch.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_branch_sequencer;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int FLUSH = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic          req      [2];
    logic [2:0]    sel      [2];
    logic [DW-1:0] rega     [2];
    logic [DW-1:0] regb     [2];
    logic [AW-1:0] tgt      [2];
    logic          ready    [2];
    logic          ulasub   [2];
    logic          pcwrite  [2];
    logic          flush    [2];
    logic          stall    [2];
    logic          resolved [2];
    logic          taken    [2];
    logic [DW-1:0] opa      [2];
    logic [DW-1:0] opb      [2];
    logic [DW-1:0] ulaout   [2];
    logic [AW-1:0] pcnext   [2];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int L = (k == 0) ? 1 : 3;
        int sub_cnt;

        always @(posedge clock) sub_cnt <= ulasub[k] ? sub_cnt + 1 : 0;

        assign ulaout[k] = (ulasub[k] && (sub_cnt >= L - 1)) ? (opa[k] - opb[k])
                                                            : 32'hDEAD_BEEF;

        branch_sequencer #(
            .DATA_WIDTH   (DW),
            .ADDR_WIDTH   (AW),
            .ULA_LATENCY  (L),
            .FLUSH_CYCLES (FLUSH)
        ) u_dut (
            .clock        (clock),
            .reset        (reset),
            .BranchReq    (req[k]),
            .BranchReady  (ready[k]),
            .BranchSelect (sel[k]),
            .RegA         (rega[k]),
            .RegB         (regb[k]),
            .BranchTarget (tgt[k]),
            .ULAopA       (opa[k]),
            .ULAopB       (opb[k]),
            .ULASub       (ulasub[k]),
            .ULAout       (ulaout[k]),
            .PCWrite      (pcwrite[k]),
            .PCNext       (pcnext[k]),
            .Flush        (flush[k]),
            .Stall        (stall[k]),
            .Resolved     (resolved[k]),
            .Taken        (taken[k])
        );
    end

    // Branch outcome straight from the condition-code definitions.
    function automatic bit exp_taken(input logic [2:0] s, input logic [DW-1:0] a,
                                     input logic [DW-1:0] b);
        logic signed [DW-1:0] d;
        d = a - b;
        case (s)
            3'd0:    return 1'b1;
            3'd1:    return d == 0;
            3'd2:    return d != 0;
            3'd3:    return d > 0;
            3'd4:    return d < 0;
            default: return 1'b0;
        endcase
    endfunction

    // Starts at a negedge with the instance idle: presents a request, then
    // checks every following cycle up to and including the first IDLE cycle.
    // Inputs are scrambled while the branch is in flight; with hold=1 the
    // request line stays high throughout.
    task automatic run_branch(input int k, input logic [2:0] s, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input logic [AW-1:0] t,
                              input bit hold, input string tag);
        int   lat, cmp_len, r_cyc, last;
        bit   tk;
        logic [6:0] got, exp;
        lat     = (k == 0) ? 1 : 3;
        cmp_len = (s >= 3'd1 && s <= 3'd4) ? lat : 0;
        r_cyc   = 1 + cmp_len;
        tk      = exp_taken(s, a, b);
        last    = tk ? r_cyc + FLUSH : r_cyc;

        n_checks++;
        if (ready[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept_ready: got %b want 1", tag, ready[k]);
        end
        req[k] = 1'b1; sel[k] = s; rega[k] = a; regb[k] = b; tgt[k] = t;

        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clock);
            // {ready, stall, ulasub, resolved, taken, pcwrite, flush}
            got = {ready[k], stall[k], ulasub[k], resolved[k], taken[k], pcwrite[k], flush[k]};
            exp[6] = (c == last + 1);
            exp[5] = (c <= last);
            exp[4] = (c <= cmp_len);
            exp[3] = (c == r_cyc);
            exp[2] = (c == r_cyc) && tk;
            exp[1] = tk && (c == r_cyc + 1);
            exp[0] = tk && (c > r_cyc) && (c <= r_cyc + FLUSH);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s ctrl cyc%0d sel=%0d: got rdy/stl/sub/res/tk/pcw/fl=%b want %b",
                         tag, c, s, got, exp);
            end
            if (c <= cmp_len) begin
                n_checks++;
                if ({opa[k], opb[k]} !== {a, b}) begin
                    n_fail++;
                    $display("FAIL %s operands cyc%0d: got %h/%h want %h/%h",
                             tag, c, opa[k], opb[k], a, b);
                end
            end
            if (exp[1]) begin
                n_checks++;
                if (pcnext[k] !== t) begin
                    n_fail++;
                    $display("FAIL %s pcnext: got %h want %h", tag, pcnext[k], t);
                end
            end
            if (c <= last) begin
                req[k]  = hold;
                sel[k]  = 3'($urandom);
                rega[k] = DW'($urandom);
                regb[k] = DW'($urandom);
                tgt[k]  = AW'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({ready[k], stall[k], ulasub[k], resolved[k], taken[k], pcwrite[k], flush[k]}
                    !== 7'b1000000 || opa[k] !== '0 || opb[k] !== '0 || pcnext[k] !== '0) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: got ctrl=%b opa=%h opb=%h pcn=%h want 1000000/0/0/0",
                         k, {ready[k], stall[k], ulasub[k], resolved[k], taken[k], pcwrite[k], flush[k]},
                         opa[k], opb[k], pcnext[k]);
            end
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_directed();
        run_branch(0, 3'b001, 32'd5, 32'd5, 32'h40, 1'b0, "beq_taken");
        run_branch(0, 3'b010, 32'd7, 32'd7, 32'h44, 1'b0, "bne_not_taken");
        run_branch(0, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'h48, 1'b0, "bgt_signed");
        run_branch(0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h4C, 1'b0, "blt_signed");
        run_branch(0, 3'b000, 32'd3, 32'd9, 32'h50, 1'b0, "jump");
        run_branch(0, 3'b101, 32'd1, 32'd1, 32'h54, 1'b0, "none_101");
        run_branch(0, 3'b111, 32'd2, 32'd1, 32'h58, 1'b0, "none_111");
        run_branch(1, 3'b001, 32'd5, 32'd5, 32'h40, 1'b0, "beq_lat3");
        run_branch(1, 3'b011, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h60, 1'b0, "bgt_overflow_lat3");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 2; k++) begin
                logic [DW-1:0] a, b;
                a = DW'($urandom);
                b = ($urandom_range(0, 2) == 0) ? a : DW'($urandom);
                run_branch(k, 3'($urandom_range(0, 7)), a, b, AW'($urandom), 1'b0, "random");
            end
        end
    endtask

    task automatic test_back_to_back();
        run_branch(1, 3'b001, 32'd11, 32'd11, 32'h100, 1'b1, "b2b_first");
        run_branch(1, 3'b010, 32'd11, 32'd11, 32'h104, 1'b1, "b2b_second");
        run_branch(1, 3'b100, 32'd1, 32'd2, 32'h108, 1'b1, "b2b_third");
        run_branch(0, 3'b000, 32'd0, 32'd0, 32'h10C, 1'b1, "b2b_lat1_first");
        run_branch(0, 3'b010, 32'd1, 32'd0, 32'h110, 1'b0, "b2b_lat1_second");
    endtask

    task automatic test_reset_mid();
        n_checks++;
        if (ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid accept_ready: got %b want 1", ready[0]);
        end
        req[0] = 1'b1; sel[0] = 3'b001; rega[0] = 32'd9; regb[0] = 32'd9; tgt[0] = 32'h80;
        @(negedge clock);
        req[0] = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (pcwrite[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid pcwrite_before_reset: got %b want 1", pcwrite[0]);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({ready[0], stall[0], ulasub[0], resolved[0], taken[0], pcwrite[0], flush[0]} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL rst_mid async_clear: got %b want 1000000",
                     {ready[0], stall[0], ulasub[0], resolved[0], taken[0], pcwrite[0], flush[0]});
        end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            n_checks++;
            if ({ready[0], pcwrite[0], flush[0], resolved[0]} !== 4'b1000) begin
                n_fail++;
                $display("FAIL rst_mid after_release cyc%0d: got rdy/pcw/fl/res=%b want 1000",
                         c, {ready[0], pcwrite[0], flush[0], resolved[0]});
            end
        end
        run_branch(0, 3'b001, 32'd4, 32'd4, 32'hC0, 1'b0, "rst_mid_new_req");
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; sel[k] = '0; rega[k] = '0; regb[k] = '0; tgt[k] = '0;
        end
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_branch_sequencer
`default_nettype wire
